// File: rtl/upcnt_sched_pkg.sv
// upcnt_sched_pkg: shared types and constants for the round-robin counter scheduler.
// Optional feature macro used by the scheduler: UPCNT_SCHED_ABORT_EN.
package upcnt_sched_pkg;

  localparam int CW_DEF   = 4;
  localparam int NREQ_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_e;

  // Width of an index able to address n requesters (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/upcnt_rr_scheduler_rr_pick.sv
// upcnt_rr_scheduler_rr_pick: combinational round-robin arbiter.
// Searches req starting at ptr+1 with wrap; returns one-hot pick, its index and a valid flag.
module upcnt_rr_scheduler_rr_pick
  import upcnt_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   pick_idx,
  output logic            valid
);

  // Walk the candidates from farthest to nearest so the nearest set bit after ptr wins.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      int  j_s;
      logic hit_s;
      j_s      = (int'(ptr) + k) % NREQ;
      hit_s    = req[j_s];
      pick     = hit_s ? (NREQ'(1) << j_s) : pick;
      pick_idx = hit_s ? IW'(j_s) : pick_idx;
      valid    = hit_s | valid;
    end
  end

endmodule

// File: rtl/upcnt_structural.sv
// upcnt_structural: CW-bit up-counter with synchronous clear (priority) and count enable.
// Shares the asynchronous active-low reset of the scheduler.
module upcnt_structural #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          a_reset,
  input  logic          start,
  input  logic          s_reset,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_r;

  // Count register: clear wins over enable, otherwise increment while start is high.
  always_ff @(posedge clk or negedge a_reset) begin
    if (!a_reset) begin
      count_r <= '0;
    end else if (s_reset) begin
      count_r <= '0;
    end else if (start) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/upcnt_rr_scheduler.sv
// upcnt_rr_scheduler: shares one CW-bit up-counter among NREQ requesters in round-robin order.
// Sequence per grant: IDLE -> CLR (counter cleared) -> RUN (count to tc) -> DONE (done pulse).
// Optional macro UPCNT_SCHED_ABORT_EN: a granted requester dropping req in CLR/RUN aborts the interval.
module upcnt_rr_scheduler
  import upcnt_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CW   = CW_DEF
) (
  input  logic             clk,
  input  logic             a_reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*CW-1:0] req_tc,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             busy,
  output logic             cnt_start,
  output logic             cnt_s_reset,
  input  logic [CW-1:0]    cnt_count
);

  localparam int IW = idx_width(NREQ);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CLR  = CLR;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]      state_r;
  logic [NREQ-1:0] gnt_r;
  logic [NREQ-1:0] done_r;
  logic [IW-1:0]   idx_r;
  logic [IW-1:0]   ptr_r;
  logic [CW-1:0]   tc_r;

  logic [NREQ-1:0] pick_s;
  logic [IW-1:0]   pick_idx_s;
  logic            pick_valid_s;
  logic            tc_hit_s;
  logic            drop_s;

  upcnt_rr_scheduler_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req      (req),
    .ptr      (ptr_r),
    .pick     (pick_s),
    .pick_idx (pick_idx_s),
    .valid    (pick_valid_s)
  );

  assign tc_hit_s = (cnt_count == tc_r);

`ifdef UPCNT_SCHED_ABORT_EN
  // The granted requester withdrew its request.
  assign drop_s = ~req[idx_r];
`else
  // Requests are only sampled in IDLE; an interval always runs to completion.
  assign drop_s = 1'b0;
`endif

  // Scheduler FSM with grant, done, winner index, latched terminal count and rr pointer.
  always_ff @(posedge clk or negedge a_reset) begin
    if (!a_reset) begin
      state_r <= S_IDLE;
      gnt_r   <= '0;
      done_r  <= '0;
      idx_r   <= '0;
      ptr_r   <= IW'(NREQ - 1);
      tc_r    <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= '0;
          if (pick_valid_s) begin
            gnt_r   <= pick_s;
            idx_r   <= pick_idx_s;
            tc_r    <= req_tc[int'(pick_idx_s)*CW +: CW];
            state_r <= S_CLR;
          end else begin
            gnt_r   <= '0;
            state_r <= S_IDLE;
          end
        end
        S_CLR: begin
          if (drop_s) begin
            gnt_r   <= '0;
            ptr_r   <= idx_r;
            state_r <= S_IDLE;
          end else begin
            state_r <= S_RUN;
          end
        end
        S_RUN: begin
          if (drop_s) begin
            gnt_r   <= '0;
            ptr_r   <= idx_r;
            state_r <= S_IDLE;
          end else if (tc_hit_s) begin
            done_r  <= gnt_r;
            state_r <= S_DONE;
          end else begin
            state_r <= S_RUN;
          end
        end
        S_DONE: begin
          done_r  <= '0;
          gnt_r   <= '0;
          ptr_r   <= idx_r;
          state_r <= S_IDLE;
        end
        default: begin
          gnt_r   <= '0;
          done_r  <= '0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt         = gnt_r;
  assign done        = done_r;
  assign busy        = (state_r != S_IDLE);
  assign cnt_s_reset = (state_r == S_CLR);
  // Enable stops as soon as the count reaches tc, so the counter holds and never wraps.
  assign cnt_start   = (state_r == S_RUN) && !tc_hit_s;

endmodule

// File: tb/tb_upcnt_rr_scheduler.sv
// tb_upcnt_rr_scheduler: directed + randomized bench for upcnt_rr_scheduler with a real counter.
// Reference model: per-transaction winner from the round-robin rule and cycle timing from the
// documented latency (gnt cycles 1..tc+3, s_reset cycle 1, start cycles 2..tc+1, done cycle tc+3).
module tb_upcnt_rr_scheduler;

  localparam int NREQ = 4;
  localparam int CW   = 4;
  localparam int TW   = NREQ * CW;

  logic            clk;
  logic            a_reset;
  logic [NREQ-1:0] req;
  logic [TW-1:0]   req_tc;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            busy;
  logic            cnt_start;
  logic            cnt_s_reset;
  logic [CW-1:0]   cnt_count;

  int vectors;
  int miscompares;
  int ptr_m;

  upcnt_rr_scheduler #(.NREQ(NREQ), .CW(CW)) dut (
    .clk         (clk),
    .a_reset     (a_reset),
    .req         (req),
    .req_tc      (req_tc),
    .gnt         (gnt),
    .done        (done),
    .busy        (busy),
    .cnt_start   (cnt_start),
    .cnt_s_reset (cnt_s_reset),
    .cnt_count   (cnt_count)
  );

  upcnt_structural #(.CW(CW)) u_cnt (
    .clk     (clk),
    .a_reset (a_reset),
    .start   (cnt_start),
    .s_reset (cnt_s_reset),
    .count   (cnt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Round-robin rule: first set request after the last winner, wrapping around.
  function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [TW-1:0] all_tc(input int v);
    logic [TW-1:0] t;
    for (int i = 0; i < NREQ; i++) t[i*CW +: CW] = CW'(v);
    return t;
  endfunction

  // One transaction starting in an IDLE cycle (called at a falling edge).
  task automatic run_txn(input logic [NREQ-1:0] r, input logic [TW-1:0] tcs,
                         input logic [NREQ-1:0] mid_or, input bit scramble);
    int win;
    int tcv;
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    req    = r;
    req_tc = tcs;
    win    = model_pick(r, ptr_m);
    if (win < 0) begin
      @(negedge clk);
      chk("noreq_busy", 32'(busy), 32'd0);
      chk("noreq_gnt", 32'(gnt), 32'd0);
      return;
    end
    tcv = int'(tcs[win*CW +: CW]);
    for (int c = 1; c <= tcv + 3; c++) begin
      @(negedge clk);
      chk("gnt", 32'(gnt), 32'd1 << win);
      chk("done", 32'(done), (c == tcv + 3) ? (32'd1 << win) : 32'd0);
      chk("s_reset", 32'(cnt_s_reset), (c == 1) ? 32'd1 : 32'd0);
      chk("start", 32'(cnt_start), (c >= 2 && c <= tcv + 1) ? 32'd1 : 32'd0);
      chk("busy", 32'(busy), 32'd1);
      if (c >= 2) chk("count", 32'(cnt_count), (c <= tcv + 2) ? 32'(c - 2) : 32'(tcv));
      if (c == 2) begin
        req = r | mid_or;
        if (scramble) req_tc = TW'($urandom);
      end
    end
    ptr_m = win;
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ptr_m       = NREQ - 1;
    a_reset     = 1'b0;
    req         = '0;
    req_tc      = '0;

    // Reset values
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(cnt_start), 32'd0);
    chk("rst_sreset", 32'(cnt_s_reset), 32'd0);
    a_reset = 1'b1;
    @(negedge clk);

    // Single requester, tc=3
    run_txn(4'b0001, all_tc(3), 4'b0000, 1'b0);
    // All requesting, tc=1: order 0,1,2,3,0
    for (int i = 0; i < 5; i++) run_txn(4'b1111, all_tc(1), 4'b0000, 1'b0);
    // Boundary terminal counts
    run_txn(4'b0010, all_tc(0), 4'b0000, 1'b0);
    run_txn(4'b0100, all_tc(15), 4'b0000, 1'b0);
    // req[2] running, req[1] arrives mid-run; tc change after grant ignored
    run_txn(4'b0100, all_tc(4), 4'b0010, 1'b1);
    run_txn(4'b0110, all_tc(2), 4'b0000, 1'b0);
    // No request
    run_txn(4'b0000, all_tc(2), 4'b0000, 1'b0);

`ifdef UPCNT_SCHED_ABORT_EN
    // Abort: granted requester 0 drops in RUN
    chk("ab_idle", 32'(busy), 32'd0);
    req    = 4'b0001;
    req_tc = all_tc(6);
    @(negedge clk);
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    chk("ab_gnt", 32'(gnt), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_start", 32'(cnt_start), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    ptr_m = 0;
    run_txn(4'b0011, all_tc(1), 4'b0000, 1'b0);
`endif

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      run_txn(NREQ'($urandom), TW'($urandom), NREQ'($urandom), 1'($urandom));
    end

    // Asynchronous reset mid-run
    req    = 4'b1000;
    req_tc = all_tc(9);
    repeat (4) @(negedge clk);
    #2 a_reset = 1'b0;
    #1;
    chk("mrst_gnt", 32'(gnt), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_start", 32'(cnt_start), 32'd0);
    chk("mrst_sreset", 32'(cnt_s_reset), 32'd0);
    chk("mrst_count", 32'(cnt_count), 32'd0);
    req = '0;
    @(negedge clk);
    a_reset = 1'b1;
    ptr_m   = NREQ - 1;
    @(negedge clk);
    run_txn(4'b1111, all_tc(2), 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
